zero_count_pipeline: RTL and testbench



---
 rtl/zero_count_pipeline.sv | 176 +++++++++++++++++
 tb/tb_zero_count_pipeline.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/zero_count_pipeline.sv
// zero_count_pipeline: two-stage CLZ / CTZ / CPOP unit for the bit-manip path.
// Stage 1 reduces the operand to per-nibble zero flags and local counts;
// stage 2 priority-encodes those into the final count.
// Optional popcount support is built when ZERO_COUNT_CPOP_EN is defined; in the
// default build mode 10 is reported as illegal like the reserved mode 11.
module zero_count_pipeline #(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic [1:0]            mode_i,
  input  logic                  valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  is_all_zero_o,
  output logic                  illegal_o,
  output logic                  valid_o
);

  localparam int NIB    = DATA_WIDTH / 4;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {
    MODE_CLZ  = 2'b00,
    MODE_CTZ  = 2'b01,
    MODE_CPOP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  if (DATA_WIDTH < 8 || DATA_WIDTH > 64 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $error("zero_count_pipeline: DATA_WIDTH must be a power of two in 8..64");
  end

  // Pipeline control: bit k is the valid of stage k
  logic [STAGES:1]           vld_pipe_q;

  // Stage 1 state
  mode_e                     s1_mode_q;
  logic [NIB-1:0]            s1_zero_d,  s1_zero_q;
  logic [NIB-1:0][1:0]       s1_lcnt_d,  s1_lcnt_q;

  // Stage 2 (output) state
  logic [CNT_WIDTH-1:0]      count_d,    count_q;
  logic                      zero_d,     zero_q;
  logic                      illegal_d,  illegal_q;

  logic [DATA_WIDTH-1:0]     oper_sel;
  logic [3:0]                nib_w;
  logic [CNT_WIDTH-1:0]      enc_cnt;
  logic                      enc_zero;

  wire adv = !flush_i && !stall_i;

`ifdef ZERO_COUNT_CPOP_EN
  logic [NIB-1:0][2:0]       s1_pop_d,   s1_pop_q;
  logic [CNT_WIDTH-1:0]      pop_sum;
`endif

  // CTZ is a CLZ of the bit-reversed operand
  always_comb begin
    oper_sel = operand_i;
    if (mode_i == MODE_CTZ)
      for (int b = 0; b < DATA_WIDTH; b++) oper_sel[b] = operand_i[DATA_WIDTH-1-b];
  end

  // Per-nibble reduction, nibble 0 is the most significant
  always_comb begin
    s1_zero_d = '0;
    s1_lcnt_d = '0;
    nib_w     = '0;
`ifdef ZERO_COUNT_CPOP_EN
    s1_pop_d  = '0;
`endif
    for (int n = 0; n < NIB; n++) begin
      nib_w        = oper_sel[DATA_WIDTH-1-4*n -: 4];
      s1_zero_d[n] = (nib_w == 4'd0);
      casez (nib_w)
        4'b1???: s1_lcnt_d[n] = 2'd0;
        4'b01??: s1_lcnt_d[n] = 2'd1;
        4'b001?: s1_lcnt_d[n] = 2'd2;
        default: s1_lcnt_d[n] = 2'd3;   // 0001, or zero nibble (flag covers it)
      endcase
`ifdef ZERO_COUNT_CPOP_EN
      s1_pop_d[n] = 3'(nib_w[0]) + 3'(nib_w[1]) + 3'(nib_w[2]) + 3'(nib_w[3]);
`endif
    end
  end

  // Valid shift register; flush clears it even while stalled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     vld_pipe_q <= '0;
    else if (flush_i) vld_pipe_q <= '0;
    else if (!stall_i) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], valid_i};
  end

  // Stage 1 data capture, only for a live operation
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_mode_q <= MODE_CLZ;
      s1_zero_q <= '0;
      s1_lcnt_q <= '0;
    end else if (adv && valid_i) begin
      s1_mode_q <= mode_e'(mode_i);
      s1_zero_q <= s1_zero_d;
      s1_lcnt_q <= s1_lcnt_d;
    end
  end

`ifdef ZERO_COUNT_CPOP_EN
  // Per-nibble popcounts travel alongside the zero flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)               s1_pop_q <= '0;
    else if (adv && valid_i)    s1_pop_q <= s1_pop_d;
  end

  // Adder tree over the nibble popcounts
  always_comb begin
    pop_sum = '0;
    for (int n = 0; n < NIB; n++) pop_sum = pop_sum + CNT_WIDTH'(s1_pop_q[n]);
  end
`endif

  // First non-zero nibble wins; scanning high index to low leaves the lowest
  always_comb begin
    enc_cnt  = CNT_WIDTH'(DATA_WIDTH);
    enc_zero = 1'b1;
    for (int n = NIB - 1; n >= 0; n--) begin
      if (!s1_zero_q[n]) begin
        enc_cnt  = CNT_WIDTH'(4 * n) + CNT_WIDTH'(s1_lcnt_q[n]);
        enc_zero = 1'b0;
      end
    end
  end

  // Stage 2 result select per mode
  always_comb begin
    count_d   = '0;
    zero_d    = 1'b0;
    illegal_d = 1'b0;
    case (s1_mode_q)
      MODE_CLZ, MODE_CTZ: begin
        count_d = enc_cnt;
        zero_d  = enc_zero;
      end
`ifdef ZERO_COUNT_CPOP_EN
      MODE_CPOP: begin
        count_d = pop_sum;
        zero_d  = (pop_sum == '0);
      end
`endif
      default: illegal_d = 1'b1;
    endcase
  end

  // Output register, loaded only when stage 1 holds a live operation
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q   <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (adv && vld_pipe_q[1]) begin
      count_q   <= count_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign count_o       = count_q;
  assign is_all_zero_o = zero_q;
  assign illegal_o     = illegal_q;
  assign valid_o       = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_zero_count_pipeline.sv
// Directed bench for zero_count_pipeline: a 32-bit instance for the main
// scenarios and an 8-bit instance for the narrow-width corner cases.
// Popcount expectations follow ZERO_COUNT_CPOP_EN.
module tb_zero_count_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;

  // 32-bit instance
  logic [31:0] op;
  logic [1:0]  mode;
  logic        vld, stall, flush;
  logic [5:0]  cnt;
  logic        az, ill, vout;

  // 8-bit instance
  logic [7:0]  op8;
  logic [1:0]  mode8;
  logic        vld8;
  logic [3:0]  cnt8;
  logic        az8, ill8, vout8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zero_count_pipeline #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .operand_i(op), .mode_i(mode),
    .valid_i(vld), .stall_i(stall), .flush_i(flush),
    .count_o(cnt), .is_all_zero_o(az), .illegal_o(ill), .valid_o(vout)
  );

  zero_count_pipeline #(.DATA_WIDTH(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .operand_i(op8), .mode_i(mode8),
    .valid_i(vld8), .stall_i(1'b0), .flush_i(1'b0),
    .count_o(cnt8), .is_all_zero_o(az8), .illegal_o(ill8), .valid_o(vout8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full result check on the 32-bit instance
  task automatic res(input string tag, input logic [5:0] c, input logic z, input logic il);
    check({tag, "_valid"}, vout, 1'b1);
    check({tag, "_count"}, cnt, c);
    check({tag, "_zero"},  az, z);
    check({tag, "_ill"},   ill, il);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic v, input logic [1:0] m, input logic [31:0] d);
    vld = v; mode = m; op = d;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; op = '0; mode = '0; vld = 0; stall = 0; flush = 0;
    op8 = '0; mode8 = '0; vld8 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", vout, 1'b0);
    check("rst_count", cnt,  6'd0);
    check("rst_zero",  az,   1'b0);
    check("rst_ill",   ill,  1'b0);
    check("rst_valid8", vout8, 1'b0);
    rst_n = 1'b1;
    cyc(0, 2'b00, 0);

    // Single CLZ: latency two
    cyc(1, 2'b00, 32'h0001_0000);
    check("lat1_valid", vout, 1'b0);
    cyc(0, 2'b00, 0);
    res("clz_10000", 6'd15, 1'b0, 1'b0);

    // Back-to-back stream; result k appears after cycle k+1
    cyc(1, 2'b01, 32'h0000_0000);
    check("bubble_valid", vout, 1'b0);
    cyc(1, 2'b00, 32'h8000_0000);
    res("ctz_zero", 6'd32, 1'b1, 1'b0);
    cyc(1, 2'b01, 32'h8000_0000);
    res("clz_msb", 6'd0, 1'b0, 1'b0);
    cyc(1, 2'b00, 32'h00F0_0000);
    res("ctz_msb", 6'd31, 1'b0, 1'b0);
    cyc(1, 2'b01, 32'h0000_0100);
    res("clz_f00000", 6'd8, 1'b0, 1'b0);
    cyc(1, 2'b10, 32'hFFFF_0001);
    res("ctz_100", 6'd8, 1'b0, 1'b0);
    cyc(0, 2'b00, 0);
`ifdef ZERO_COUNT_CPOP_EN
    res("cpop", 6'd17, 1'b0, 1'b0);
`else
    res("cpop_off", 6'd0, 1'b0, 1'b1);
`endif
    cyc(0, 2'b00, 0);
    check("drain_valid", vout, 1'b0);

    // Stall with two ops in flight; op3 is held by the issuer
    cyc(1, 2'b00, 32'h0000_0001);
    cyc(1, 2'b01, 32'h0000_0002);
    res("pre_stall", 6'd31, 1'b0, 1'b0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b00, 32'hFFFF_FFFF);
      res("stall_hold", 6'd31, 1'b0, 1'b0);
    end
    stall = 0;
    cyc(1, 2'b00, 32'hFFFF_FFFF);
    res("post_stall_op2", 6'd1, 1'b0, 1'b0);
    cyc(0, 2'b00, 0);
    res("post_stall_op3", 6'd0, 1'b0, 1'b0);
    cyc(0, 2'b00, 0);
    check("no_dup_valid", vout, 1'b0);

    // Flush with two ops in flight plus a new one presented
    cyc(1, 2'b00, 32'h0000_0001);
    cyc(1, 2'b00, 32'h0000_0002);
    res("pre_flush", 6'd31, 1'b0, 1'b0);
    flush = 1;
    cyc(1, 2'b00, 32'h0000_0004);
    flush = 0;
    check("flush_v1", vout, 1'b0);
    cyc(0, 2'b00, 0);
    check("flush_v2", vout, 1'b0);
    cyc(1, 2'b00, 32'h0000_0100);
    check("fresh_lat", vout, 1'b0);
    cyc(0, 2'b00, 0);
    res("fresh_op", 6'd23, 1'b0, 1'b0);

    // Flush beats stall
    cyc(1, 2'b00, 32'h0000_0001);
    flush = 1; stall = 1;
    cyc(0, 2'b00, 0);
    flush = 0; stall = 0;
    check("flush_stall_v1", vout, 1'b0);
    cyc(0, 2'b00, 0);
    check("flush_stall_v2", vout, 1'b0);

    // Reserved mode
    cyc(1, 2'b11, 32'h1234_5678);
    cyc(0, 2'b00, 0);
    res("rsvd", 6'd0, 1'b0, 1'b1);

    // Narrow instance: CLZ 0x01 then CLZ 0x00
    vld8 = 1; mode8 = 2'b00; op8 = 8'h01;
    @(posedge clk); #1;
    op8 = 8'h00;
    @(posedge clk); #1;
    vld8 = 0;
    check("w8_valid", vout8, 1'b1);
    check("w8_clz01", cnt8, 4'd7);
    check("w8_zero01", az8, 1'b0);
    @(posedge clk); #1;
    check("w8_clz00", cnt8, 4'd8);
    check("w8_zero00", az8, 1'b1);

    // Asynchronous reset drops valid_o without a clock edge
    cyc(1, 2'b00, 32'h0000_0001);
    cyc(0, 2'b00, 0);
    check("pre_areset_valid", vout, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", vout, 1'b0);
    check("areset_count", cnt, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
